// File: rtl/mem_pkg.sv
// Shared types for the memory responder slice.
// Bus request bundle, FSM states and word geometry.
package mem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [31:0]       addr;
    logic [WORD_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_array.sv
// Single-port byte-laned RAM, one-cycle registered read.
// INIT_FILE kept for interface compatibility; contents undefined.
module mem_array
  import mem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = "",
  localparam int   AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [AW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) begin
            r_mem[idx][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= r_mem[idx];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Wait-stated memory responder: one request at a time, served from mem_array.
// Define MEM_ERR_RESP_EN to flag misaligned/out-of-range requests with rsp_err.
module mem_responder
  import mem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [BE_W-1:0]   req_be,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int         AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  mem_state_t        r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  mem_req_t          r_req;
  logic              r_err;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic              w_accept;
  logic              w_req_err;
  logic              w_mem_en;
  logic [AW-1:0]     w_idx;
  logic [WORD_W-1:0] w_rdata;
  logic              w_unused;

  assign req_ready = (r_state == IDLE);
  assign w_accept  = ce & req_valid & req_ready;
  assign w_idx     = r_req.addr[AW+1:2];
  assign w_unused  = ^{r_req.addr[31:AW+2], r_req.addr[1:0]};

`ifdef MEM_ERR_RESP_EN
  assign w_req_err = (req_addr[1:0] != 2'b00) ||
                     (req_addr[31:AW+2] != '0);
  assign rsp_err   = r_rsp_valid & r_err;
`else
  assign w_req_err = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  // RESP spends its first cycle on the RAM access; rsp_valid follows it.
  assign w_mem_en = ce & ~reset & (r_state == RESP) &
                    ~r_rsp_valid & ~r_err;

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = (r_rsp_valid & ~r_req.we & ~r_err) ?
                     w_rdata : '0;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_rsp_valid_nxt = r_rsp_valid;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (WS == 4'd0) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = WS;
          end
        end
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_nxt = RESP;
      end
      RESP: begin
        if (!r_rsp_valid) begin
          w_rsp_valid_nxt = 1'b1;
        end else if (rsp_ready) begin
          w_state_nxt     = IDLE;
          w_rsp_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_req       <= '0;
    end else if (ce) begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      if (w_accept) begin
        r_req <= '{we: req_we, be: req_be,
                   addr: req_addr, wdata: req_wdata};
        r_err <= w_req_err;
      end
    end
  end

  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_mem (
    .clk   (clk),
    .en    (w_mem_en),
    .we    (r_req.we),
    .be    (r_req.be),
    .idx   (w_idx),
    .wdata (r_req.wdata),
    .rdata (w_rdata)
  );

endmodule
